// File: rtl/c880_chk_pkg.sv
// Shared types and constants for the c880 response checking flow.
// Also used by the stimulus side, which compacts the 60-bit c880 inputs.
package c880_chk_pkg;

    localparam int unsigned C880_OUT_WIDTH = 26;
    localparam int unsigned C880_IN_WIDTH  = 60;

    // x^26 + x^6 + x^2 + x + 1
    localparam logic [C880_OUT_WIDTH-1:0] C880_MISR_POLY = 26'h0000047;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

endpackage : c880_chk_pkg

// File: rtl/c880_misr.sv
// Multiple-input signature register.
// Shift left, feed back the taps when the MSB falls out, then fold in din.
module c880_misr
    import c880_chk_pkg::*;
#(
    parameter int unsigned             OUT_WIDTH = C880_OUT_WIDTH,
    parameter logic [OUT_WIDTH-1:0]    POLY      = OUT_WIDTH'(C880_MISR_POLY),
    parameter logic [OUT_WIDTH-1:0]    SEED      = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    input  logic [OUT_WIDTH-1:0] din,
    output logic [OUT_WIDTH-1:0] sig
);

    logic [OUT_WIDTH-1:0] fb;
    logic [OUT_WIDTH-1:0] sig_next;

    always_comb begin
        fb       = sig[OUT_WIDTH-1] ? POLY : '0;
        sig_next = {sig[OUT_WIDTH-2:0], 1'b0} ^ fb ^ din;
    end

    // load takes priority over a compaction step in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule : c880_misr

// File: rtl/c880_response_checker.sv
// Capture/compare end of the c880 vector flow: checks each response against a
// golden memory, counts mismatches, records the first failure and a signature.
module c880_response_checker
    import c880_chk_pkg::*;
#(
    parameter int unsigned          OUT_WIDTH  = C880_OUT_WIDTH,
    parameter int unsigned          VEC_LENGTH = 64,
    parameter int unsigned          ADDR_W     = 6,
    parameter int unsigned          CNT_W      = 7,
    parameter logic [OUT_WIDTH-1:0] MISR_POLY  = OUT_WIDTH'(C880_MISR_POLY),
    parameter logic [OUT_WIDTH-1:0] MISR_SEED  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 resp_valid,
    input  logic [OUT_WIDTH-1:0] resp_data,
    input  logic                 exp_wr_en,
    input  logic [ADDR_W-1:0]    exp_wr_addr,
    input  logic [OUT_WIDTH-1:0] exp_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic [ADDR_W-1:0]    first_fail_idx,
    output logic [OUT_WIDTH-1:0] first_fail_xor,
    output logic [OUT_WIDTH-1:0] signature
);

    localparam int unsigned        MEM_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(VEC_LENGTH - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(VEC_LENGTH);
    localparam logic [ADDR_W:0]    VEC_LIM   = (ADDR_W + 1)'(VEC_LENGTH);

    chk_state_e state, state_d;

    logic [ADDR_W-1:0]    idx, idx_d;
    logic [CNT_W-1:0]     cnt_d;
    logic [ADDR_W-1:0]    ffi_d;
    logic [OUT_WIDTH-1:0] ffx_d;
    logic                 ff_seen, ff_seen_d;
    logic                 busy_d, done_d, pass_d;

    logic [OUT_WIDTH-1:0] mem [MEM_DEPTH];
    logic [OUT_WIDTH-1:0] exp_c;
    logic [OUT_WIDTH-1:0] diff_c;
    logic                 mm_c;
    logic                 accept_c;
    logic                 wr_ok_c;

    // Golden memory: writable only while no run is in progress, never reset
    assign wr_ok_c = exp_wr_en && (state != RUN) && ({1'b0, exp_wr_addr} < VEC_LIM);

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[exp_wr_addr] <= exp_wr_data;
        end
    end

    assign exp_c    = mem[idx];
    assign diff_c   = resp_data ^ exp_c;
    assign mm_c     = (diff_c != '0);
    // a start in the same cycle discards the response
    assign accept_c = (state == RUN) && resp_valid && !start;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = mismatch_count;
        ffi_d     = first_fail_idx;
        ffx_d     = first_fail_xor;
        ff_seen_d = ff_seen;

        if (start) begin
            state_d   = RUN;
            idx_d     = '0;
            cnt_d     = '0;
            ffi_d     = '0;
            ffx_d     = '0;
            ff_seen_d = 1'b0;
        end else if (accept_c) begin
            if (mm_c) begin
                if (mismatch_count != CNT_MAX) begin
                    cnt_d = mismatch_count + CNT_W'(1);
                end
                if (!ff_seen) begin
                    ffi_d     = idx;
                    ffx_d     = diff_c;
                    ff_seen_d = 1'b1;
                end
            end
            if (idx == LAST_IDX) begin
                state_d = DONE;
                idx_d   = '0;
            end else begin
                idx_d = idx + ADDR_W'(1);
            end
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = done_d && (cnt_d == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Registered run bookkeeping and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            first_fail_xor <= '0;
            ff_seen        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            idx            <= idx_d;
            mismatch_count <= cnt_d;
            first_fail_idx <= ffi_d;
            first_fail_xor <= ffx_d;
            ff_seen        <= ff_seen_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
        end
    end

    c880_misr #(
        .OUT_WIDTH (OUT_WIDTH),
        .POLY      (MISR_POLY),
        .SEED      (MISR_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (start),
        .en   (accept_c),
        .din  (resp_data),
        .sig  (signature)
    );

endmodule : c880_response_checker

// File: tb/tb_c880_response_checker.sv
// Directed bench for c880_response_checker: table-driven full runs plus
// hand-written MISR, restart, reset and write-blocking sequences.
module tb_c880_response_checker;

    localparam int unsigned W   = 26;
    localparam int unsigned VL  = 64;
    localparam int unsigned AW  = 6;
    localparam int unsigned CW  = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          resp_valid;
    logic [W-1:0]  resp_data;
    logic          exp_wr_en;
    logic [AW-1:0] exp_wr_addr;
    logic [W-1:0]  exp_wr_data;
    logic          busy, done, pass;
    logic [CW-1:0] mismatch_count;
    logic [AW-1:0] first_fail_idx;
    logic [W-1:0]  first_fail_xor;
    logic [W-1:0]  signature;

    int n_vec  = 0;
    int n_miss = 0;
    logic [W-1:0] sig_m;

    c880_response_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .exp_wr_en      (exp_wr_en),
        .exp_wr_addr    (exp_wr_addr),
        .exp_wr_data    (exp_wr_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_count (mismatch_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_xor (first_fail_xor),
        .signature      (signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           fa, ba, fb, bb;   // up to two bit flips: vector, bit (-1 = none)
        int           gap;              // max idle cycles before each valid
        int           exp_cnt;
        int           exp_ffi;
        logic [W-1:0] exp_ffx;
        logic         exp_pass;
    } row_t;

    row_t rows [5];

    function automatic logic [W-1:0] gold(input int k);
        return W'(k * 32'h0012345);
    endfunction

    function automatic logic [W-1:0] misr_ref(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] n;
        n = {s[W-2:0], 1'b0} ^ d;
        if (s[W-1]) n = n ^ 26'h0000047;
        return n;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic with_valid);
        start      = 1'b1;
        resp_valid = with_valid;
        resp_data  = W'($urandom);
        cyc();
        start      = 1'b0;
        resp_valid = 1'b0;
        sig_m      = '0;
    endtask

    // Drives n valid responses for vectors k0..k0+n-1, with optional flips and gaps
    task automatic run_vec(input int k0, input int n, input int fa, input int ba,
                           input int fb, input int bb, input int gap, input logic wr_junk,
                           output logic busy_ok);
        logic [W-1:0] d;
        busy_ok = 1'b1;
        for (int k = k0; k < k0 + n; k++) begin
            repeat ($urandom_range(gap, 0)) begin
                resp_valid = 1'b0;
                resp_data  = W'($urandom);
                cyc();
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            d = gold(k);
            if (k == fa) d = d ^ (W'(1) << ba);
            if (k == fb) d = d ^ (W'(1) << bb);
            resp_valid = 1'b1;
            resp_data  = d;
            if (wr_junk) begin
                exp_wr_en   = 1'b1;
                exp_wr_addr = AW'((k + 5) % VL);
                exp_wr_data = ~gold((k + 5) % VL);
            end
            sig_m = misr_ref(sig_m, d);
            cyc();
            resp_valid = 1'b0;
            exp_wr_en  = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_cnt"},  32'(mismatch_count), 0);
        check({tag, "_ffi"},  32'(first_fail_idx), 0);
        check({tag, "_ffx"},  32'(first_fail_xor), 0);
        check({tag, "_sig"},  32'(signature), 0);
    endtask

    initial begin
        logic bok;

        rows[0] = '{"all_match",  -1, 0, -1, 0, 0, 0,  0, 26'h0000000, 1'b1};
        rows[1] = '{"bit3_vec5",   5, 3, -1, 0, 0, 1,  5, 26'h0000008, 1'b0};
        rows[2] = '{"gaps",       -1, 0, -1, 0, 3, 0,  0, 26'h0000000, 1'b1};
        rows[3] = '{"two_faults",  0, 25, 63, 0, 0, 2, 0, 26'h2000000, 1'b0};
        rows[4] = '{"gap_fault",  40, 12, -1, 0, 2, 1, 40, 26'h0001000, 1'b0};

        rst = 1'b1; start = 1'b0; resp_valid = 1'b0; resp_data = '0;
        exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0; sig_m = '0;
        cyc(); cyc();
        rst = 1'b0;
        check_reset_vals("reset");

        for (int i = 0; i < int'(VL); i++) begin
            exp_wr_en = 1'b1; exp_wr_addr = AW'(i); exp_wr_data = gold(i);
            cyc();
        end
        exp_wr_en = 1'b0;

        // Full runs from the table; done must rise exactly one cycle after the 64th valid
        foreach (rows[r]) begin
            pulse_start(1'b0);
            check({rows[r].name, "_busy_start"}, 32'(busy), 1);
            run_vec(0, 63, rows[r].fa, rows[r].ba, rows[r].fb, rows[r].bb, rows[r].gap, 1'b0, bok);
            check({rows[r].name, "_done_early"}, 32'(done), 0);
            run_vec(63, 1, rows[r].fa, rows[r].ba, rows[r].fb, rows[r].bb, rows[r].gap, 1'b0, bok);
            check({rows[r].name, "_busy_ok"}, 32'(bok), 1);
            check({rows[r].name, "_done"}, 32'(done), 1);
            check({rows[r].name, "_busy_end"}, 32'(busy), 0);
            check({rows[r].name, "_pass"}, 32'(pass), 32'(rows[r].exp_pass));
            check({rows[r].name, "_cnt"}, 32'(mismatch_count), 32'(rows[r].exp_cnt));
            check({rows[r].name, "_ffi"}, 32'(first_fail_idx), 32'(rows[r].exp_ffi));
            check({rows[r].name, "_ffx"}, 32'(first_fail_xor), 32'(rows[r].exp_ffx));
            check({rows[r].name, "_sig"}, 32'(signature), 32'(sig_m));
        end

        // Responses in DONE are ignored; status holds
        repeat (3) begin
            resp_valid = 1'b1; resp_data = W'($urandom);
            cyc();
        end
        resp_valid = 1'b0;
        check("done_hold_sig", 32'(signature), 32'(sig_m));
        check("done_hold_done", 32'(done), 1);
        check("done_hold_cnt", 32'(mismatch_count), 1);

        // MISR steps with hand-computed signatures
        pulse_start(1'b0);
        check("misr_seed", 32'(signature), 0);
        resp_valid = 1'b1; resp_data = 26'h0000001; cyc();
        check("misr_1", 32'(signature), 32'h0000001);
        resp_data = 26'h0000000; cyc();
        check("misr_2", 32'(signature), 32'h0000002);
        resp_valid = 1'b0;
        pulse_start(1'b0);
        resp_valid = 1'b1; resp_data = 26'h2000000; cyc();
        check("misr_msb", 32'(signature), 32'h2000000);
        resp_data = 26'h0000000; cyc();
        check("misr_fb", 32'(signature), 32'h0000047);
        resp_valid = 1'b0;

        // Restart at vector 30, with a response in the start cycle that must be discarded
        pulse_start(1'b0);
        run_vec(0, 30, 2, 7, -1, 0, 0, 1'b0, bok);
        check("pre_restart_cnt", 32'(mismatch_count), 1);
        pulse_start(1'b1);
        check("restart_busy", 32'(busy), 1);
        check("restart_cnt", 32'(mismatch_count), 0);
        check("restart_ffx", 32'(first_fail_xor), 0);
        check("restart_sig", 32'(signature), 0);
        run_vec(0, 63, -1, 0, -1, 0, 0, 1'b0, bok);
        check("restart_done_early", 32'(done), 0);
        run_vec(63, 1, -1, 0, -1, 0, 0, 1'b0, bok);
        check("restart_done", 32'(done), 1);
        check("restart_pass", 32'(pass), 1);
        check("restart_sig_end", 32'(signature), 32'(sig_m));

        // rst at vector 30 beats a simultaneous start; golden memory survives
        pulse_start(1'b0);
        run_vec(0, 30, 4, 1, -1, 0, 0, 1'b0, bok);
        rst = 1'b1; start = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0;
        check_reset_vals("midrun_rst");
        pulse_start(1'b0);
        run_vec(0, 64, -1, 0, -1, 0, 1, 1'b0, bok);
        check("after_rst_pass", 32'(pass), 1);
        check("after_rst_sig", 32'(signature), 32'(sig_m));

        // Writes during RUN are ignored
        pulse_start(1'b0);
        run_vec(0, 64, -1, 0, -1, 0, 0, 1'b1, bok);
        check("wrblock_pass", 32'(pass), 1);
        check("wrblock_cnt", 32'(mismatch_count), 0);
        pulse_start(1'b0);
        run_vec(0, 64, -1, 0, -1, 0, 0, 1'b0, bok);
        check("wrblock_rerun_pass", 32'(pass), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_c880_response_checker

// File: doc/c880_response_checker.md
Name: c880_response_checker

Overview:
- Synthesizable capture and compare end of the c880 vector flow. Stimulus side drives one 60-bit vector per cycle into c880; this block consumes the 26-bit c880 response per cycle.
- Compares each response against a golden vector memory and counts mismatches.
- Records the first failing vector and compacts all responses into a MISR signature.
- Replaces per-cycle file dumping for long aging runs; one pass/fail plus signature per run.

Parameters:
- OUT_WIDTH, 26, response width (c880 primary outputs N388..N880, MSB = N388).
- VEC_LENGTH, 64, vectors per run.
- ADDR_W, 6, golden memory address width; must satisfy 2**ADDR_W >= VEC_LENGTH.
- CNT_W, 7, mismatch counter width; equals clog2(VEC_LENGTH+1).
- MISR_POLY, 26'h0000047, MISR feedback taps (x^26+x^6+x^2+x+1).
- MISR_SEED, 26'h0000000, signature value loaded on start.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE, restarts from RUN.
- resp_valid  in  1  resp_data holds a c880 response this cycle.
- resp_data  in  OUT_WIDTH  c880 response, bit order as in the MSB note above.
- exp_wr_en  in  1  golden memory write strobe.
- exp_wr_addr  in  ADDR_W  golden write address.
- exp_wr_data  in  OUT_WIDTH  golden response.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done and mismatch_count==0.
- mismatch_count  out  CNT_W  number of mismatching vectors in the current/last run.
- first_fail_idx  out  ADDR_W  index of the first mismatching vector.
- first_fail_xor  out  OUT_WIDTH  resp_data XOR expected value at the first failure.
- signature  out  OUT_WIDTH  MISR state.

Behaviour:
- Reset: state=IDLE, idx=0; busy, done, pass=0; mismatch_count=0, first_fail_idx=0, first_fail_xor=0; signature=MISR_SEED. Golden memory is not cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE --start--> RUN. DONE --start--> RUN. RUN --start--> RUN, restart.
- Any start: idx=0, count/first_fail cleared, signature=MISR_SEED, first-fail flag cleared.
- Golden memory is a register array with a combinational read at idx.
  - exp_wr_en is honoured only in IDLE/DONE; it is ignored in RUN.
  - Writes with exp_wr_addr >= VEC_LENGTH are ignored.
- RUN, resp_valid=1, all updates visible the next cycle (1-cycle latency):
  - mm = (resp_data != mem[idx]).
  - If mm: mismatch_count+1, saturating at VEC_LENGTH.
  - If mm and no earlier failure this run: first_fail_idx=idx, first_fail_xor=resp_data^mem[idx], set flag.
  - signature = {sig[W-2:0],1'b0} ^ (sig[W-1] ? MISR_POLY : 0) ^ resp_data.
  - If idx==VEC_LENGTH-1: go to DONE, idx=0. Otherwise idx+1.
- RUN, resp_valid=0: hold all state. Gaps of any length are legal.
- resp_valid outside RUN is ignored.
- start with resp_valid in the same cycle: start wins and the response is discarded.
- rst in any state has priority over start and returns to reset values the next cycle.
- pass and done stay stable in DONE until start or rst.

Decomposition:
- Package c880_chk_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - C880_OUT_WIDTH=26;
  - C880_IN_WIDTH=60;
  - the default MISR_POLY constant.
- One sub-module, c880_misr: OUT_WIDTH/POLY/SEED parameters; clk, rst, load, en, din, sig ports. It is reused by the stimulus side for input compaction.

Test Plan:
- All-match run: load mem[i]=i*26'h0012345 (truncated), start, drive matching responses for 64 cycles -> done=1 exactly 1 cycle after the 64th valid, pass=1, mismatch_count=0.
- Single fault: same golden values, flip bit 3 at vector 5 -> mismatch_count=1, first_fail_idx=5, first_fail_xor=26'h0000008, pass=0.
- MISR check: seed 0, responses 26'h0000001 then 26'h0000000 -> signature 26'h0000001 then 26'h0000002; 26'h2000000 followed by 0 -> 26'h0000047.
- Valid gaps: insert random 0-3 idle cycles between the 64 valids -> results identical to the gap-free run; busy high throughout.
- Restart and reset: start at vector 30 -> count and index cleared, a fresh 64 vectors are needed for done. rst at vector 30 -> all outputs at reset values, golden memory retained (rerun passes).
- Write blocking: exp_wr_en during RUN with wrong data -> golden memory unchanged, run passes.
